// File: rtl/fifo_access_arbiter_if.sv
// Bus bundle between the two queue clients, the key configuration port,
// the cipher queue and the arbiter that sequences it.
//   slave  : arbiter view (drives acks, read data, queue controls)
//   master : environment view (clients, config, and the queue itself)
interface fifo_access_arbiter_if #(
    parameter int DATA_W = 32
);
    // client 0
    logic              c0_wr_req;
    logic [DATA_W-1:0] c0_wr_data;
    logic              c0_wr_ack;
    logic              c0_rd_req;
    logic              c0_rd_ack;
    logic [DATA_W-1:0] c0_rd_data;

    // client 1
    logic              c1_wr_req;
    logic [DATA_W-1:0] c1_wr_data;
    logic              c1_wr_ack;
    logic              c1_rd_req;
    logic              c1_rd_ack;
    logic [DATA_W-1:0] c1_rd_data;

    // key configuration and status
    logic              cfg_key_we;
    logic [DATA_W-1:0] cfg_key;
    logic              cfg_err;
    logic              busy;

    // queue control and status
    logic              q_cen;
    logic              q_rst;
    logic              q_rw;
    logic [DATA_W-1:0] q_data_in;
    logic [DATA_W-1:0] q_key;
    logic              q_empty;
    logic              q_full;
    logic              q_last;
    logic [DATA_W-1:0] q_data_out;

    modport slave (
        input  c0_wr_req, c0_wr_data, c0_rd_req,
        input  c1_wr_req, c1_wr_data, c1_rd_req,
        input  cfg_key_we, cfg_key,
        input  q_empty, q_full, q_last, q_data_out,
        output c0_wr_ack, c0_rd_ack, c0_rd_data,
        output c1_wr_ack, c1_rd_ack, c1_rd_data,
        output cfg_err, busy,
        output q_cen, q_rst, q_rw, q_data_in, q_key
    );

    modport master (
        output c0_wr_req, c0_wr_data, c0_rd_req,
        output c1_wr_req, c1_wr_data, c1_rd_req,
        output cfg_key_we, cfg_key,
        output q_empty, q_full, q_last, q_data_out,
        input  c0_wr_ack, c0_rd_ack, c0_rd_data,
        input  c1_wr_ack, c1_rd_ack, c1_rd_data,
        input  cfg_err, busy,
        input  q_cen, q_rst, q_rw, q_data_in, q_key
    );
endinterface

// File: rtl/fifo_access_arbiter.sv
// Shares the 48x32 cipher queue between two clients, each with a read and a
// write channel. Four request slots are arbitrated round-robin, one queue
// operation per four-cycle IDLE -> CMD -> WAIT -> ACK pass. Every output is
// registered, so each output register is loaded from the next-state view.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | arbitrate eligible slots, accept key loads while queue is empty
// CMD     | queue enable high, rw/data presented; queue acts on exiting edge
// WAIT    | queue flags/data settle; read data captured on exiting edge
// ACK     | one ack pulse to the granted slot; pointer moves past the grant
//
// Slot encoding: bit 0 = write, bit 1 = client 1.
//   0 = c0_rd, 1 = c0_wr, 2 = c1_rd, 3 = c1_wr
module fifo_access_arbiter #(
    parameter int              DATA_W    = 32,
    parameter logic [DATA_W-1:0] KEY_RESET = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    fifo_access_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [1:0]        grant_q, grant_d;
    logic              q_cen_q, q_cen_d;
    logic              q_rst_q, q_rst_d;
    logic              q_rw_q, q_rw_d;
    logic [DATA_W-1:0] q_data_in_q, q_data_in_d;
    logic [DATA_W-1:0] q_key_q, q_key_d;
    logic [3:0]        ack_q, ack_d;
    logic [DATA_W-1:0] c0_rd_data_q, c0_rd_data_d;
    logic [DATA_W-1:0] c1_rd_data_q, c1_rd_data_d;
    logic              cfg_err_q, cfg_err_d;
    logic              busy_q, busy_d;

    logic [3:0]        elig;
    logic              gnt_valid;
    logic [1:0]        gnt_slot;
    logic [1:0]        scan_idx;

    // q_last is only observed by the surrounding system
    logic              unused_q_last;
    assign unused_q_last = bus.q_last;

    // Which slots could be served right now given the queue flags.
    always_comb begin
        elig[0] = bus.c0_rd_req & ~bus.q_empty;
        elig[1] = bus.c0_wr_req & ~bus.q_full;
        elig[2] = bus.c1_rd_req & ~bus.q_empty;
        elig[3] = bus.c1_wr_req & ~bus.q_full;
    end

    // Round-robin pick: first eligible slot scanning upward from ptr_q.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_slot  = ptr_q;
        scan_idx  = ptr_q;
        for (int i = 0; i < 4; i++) begin
            scan_idx = ptr_q + 2'(i);
            if (!gnt_valid && elig[scan_idx]) begin
                gnt_valid = 1'b1;
                gnt_slot  = scan_idx;
            end
        end
    end

    // Next-state and next-output logic for the sequencing FSM.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        grant_d      = grant_q;
        q_cen_d      = 1'b0;
        q_rst_d      = 1'b0;
        q_rw_d       = 1'b0;
        q_data_in_d  = '0;
        q_key_d      = q_key_q;
        ack_d        = 4'b0000;
        c0_rd_data_d = c0_rd_data_q;
        c1_rd_data_d = c1_rd_data_q;
        cfg_err_d    = cfg_err_q;

        case (state_q)
            ST_IDLE: begin
                // a key change is only safe when nothing is stored under the old key
                if (bus.cfg_key_we) begin
                    if (bus.q_empty) begin
                        q_key_d = bus.cfg_key;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
                if (gnt_valid) begin
                    state_d = ST_CMD;
                    grant_d = gnt_slot;
                    q_cen_d = 1'b1;
                    q_rw_d  = gnt_slot[0];
                    if (gnt_slot[0]) begin
                        q_data_in_d = gnt_slot[1] ? bus.c1_wr_data : bus.c0_wr_data;
                    end
                end
            end
            ST_CMD: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                state_d        = ST_ACK;
                ack_d[grant_q] = 1'b1;
                if (!grant_q[0]) begin
                    if (grant_q[1]) begin
                        c1_rd_data_d = bus.q_data_out;
                    end else begin
                        c0_rd_data_d = bus.q_data_out;
                    end
                end
            end
            ST_ACK: begin
                // no arbitration here so a requester can drop req after its ack
                state_d = ST_IDLE;
                ptr_d   = grant_q + 2'd1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.cfg_key_we && (state_q != ST_IDLE)) begin
            cfg_err_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; reset holds the queue in clear.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= 2'd0;
            grant_q      <= 2'd0;
            q_cen_q      <= 1'b1;
            q_rst_q      <= 1'b1;
            q_rw_q       <= 1'b0;
            q_data_in_q  <= '0;
            q_key_q      <= KEY_RESET;
            ack_q        <= 4'b0000;
            c0_rd_data_q <= '0;
            c1_rd_data_q <= '0;
            cfg_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            grant_q      <= grant_d;
            q_cen_q      <= q_cen_d;
            q_rst_q      <= q_rst_d;
            q_rw_q       <= q_rw_d;
            q_data_in_q  <= q_data_in_d;
            q_key_q      <= q_key_d;
            ack_q        <= ack_d;
            c0_rd_data_q <= c0_rd_data_d;
            c1_rd_data_q <= c1_rd_data_d;
            cfg_err_q    <= cfg_err_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.c0_rd_ack  = ack_q[0];
    assign bus.c0_wr_ack  = ack_q[1];
    assign bus.c1_rd_ack  = ack_q[2];
    assign bus.c1_wr_ack  = ack_q[3];
    assign bus.c0_rd_data = c0_rd_data_q;
    assign bus.c1_rd_data = c1_rd_data_q;
    assign bus.cfg_err    = cfg_err_q;
    assign bus.busy       = busy_q;
    assign bus.q_cen      = q_cen_q;
    assign bus.q_rst      = q_rst_q;
    assign bus.q_rw       = q_rw_q;
    assign bus.q_data_in  = q_data_in_q;
    assign bus.q_key      = q_key_q;

endmodule
